param_updown_counter: RTL

Parametrised successor to the team's 4-bit up/down counter. It adds configurable width, an arbitrary modulus, wrap or saturate mode, a variable step, a synchronous load, count enable, boundary flags, and overflow/underflow pulses. It is used as a general event/position counter wherever a bounded bidirectional count is needed (decade counters, pointer tracking, credit counters).

---
 rtl/param_updown_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// param_updown_counter
//   Bounded bidirectional counter over 0..MAX_COUNT with wrap or saturate
//   behaviour, a variable step, a synchronous load and boundary flags.
//
// Parameters:
//   WIDTH     - count register width
//   MAX_COUNT - highest legal count (1 .. 2**WIDTH-1)
//   SATURATE  - 0: wrap modulo MAX_COUNT+1, 1: clamp at 0 / MAX_COUNT
//   STEP_W    - width of step input (2**STEP_W-1 <= MAX_COUNT+1)
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   en       - count enable
//   updown   - 1 = up, 0 = down
//   step     - unsigned step amount, 0 holds
//   load     - synchronous load strobe (priority over en)
//   load_val - value loaded, clipped to MAX_COUNT
//   count    - registered count
//   at_max   - count == MAX_COUNT
//   at_min   - count == 0
//   ovf      - registered pulse: last up-update passed MAX_COUNT
//   unf      - registered pulse: last down-update went below 0
module param_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter bit SATURATE  = 1'b0,
  parameter int STEP_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              updown,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf,
  output logic              unf
);

  if (MAX_COUNT < 1 || longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("param_updown_counter: MAX_COUNT out of range");
  end
  if (((longint'(1) << STEP_W) - 1) > longint'(MAX_COUNT) + 1) begin : g_bad_step
    $error("param_updown_counter: STEP_W too wide for MAX_COUNT");
  end

  // One extra bit so the up-sum and the wrapped down value never overflow.
  localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   MODV = (WIDTH+1)'(longint'(MAX_COUNT) + 1);
  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAX_COUNT);

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   load_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] count_n;
  logic             ovf_n;
  logic             unf_n;

  assign cnt_x  = {1'b0, count};
  assign step_x = (WIDTH+1)'(step);
  assign load_x = {1'b0, load_val};
  assign sum    = cnt_x + step_x;

  always_comb begin
    count_n = count;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    if (load) begin
      count_n = (load_x > MAXV) ? MAXW : load_val;
    end else if (en) begin
      if (updown) begin
        if (sum > MAXV) begin
          ovf_n   = 1'b1;
          count_n = SATURATE ? MAXW : WIDTH'(sum - MODV);
        end else begin
          count_n = WIDTH'(sum);
        end
      end else begin
        if (step_x > cnt_x) begin
          unf_n   = 1'b1;
          // cnt_x + MODV - step_x stays within MAX_COUNT since step > count.
          count_n = SATURATE ? '0 : WIDTH'(cnt_x + MODV - step_x);
        end else begin
          count_n = WIDTH'(cnt_x - step_x);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_n;
      ovf   <= ovf_n;
      unf   <= unf_n;
    end
  end

  assign at_max = (count == MAXW);
  assign at_min = (count == '0);

endmodule
